pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//  Parametrised pipeline stage register with valid/ready handshake, for use between
//  any two pipeline stages (IF/ID .. MEM/WB). Replaces the fixed-field, always-load
//  stage registers: generic payload width, back-pressure, flush, and a 2-entry skid
//  buffer so in_ready is a registered signal (no comb path out_ready -> in_ready).
// PARAMETERS
//  DATA_W      38   payload width (e.g. {RegWrite, WriteData[31:0], rt_Or_rd[4:0]})
//  RESET_DATA  0    value loaded into both data registers on rst
//  CNT_W       16   stall counter width (used only with PIPE_STALL_CNT_EN)
// PORTS
//  clk        in   1       clock, all state updates on posedge
//  rst        in   1       synchronous reset, active-high
//  flush      in   1       discard all held entries (branch/exception squash)
//  in_valid   in   1       upstream presents in_data
//  in_ready   out  1       stage can accept; registered
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       out_data holds a valid entry
//  out_ready  in   1       downstream accepts this cycle
//  out_data   out  DATA_W  payload to downstream; driven from main register only
//  stall_cnt  out  CNT_W   stall cycles counted (present only with PIPE_STALL_CNT_EN)
// BEHAVIOUR
//  - Storage: main {m_valid, m_data}, skid {s_valid, s_data}. out_valid=m_valid,
//    out_data=m_data, in_ready=~s_valid. Transfer = valid & ready on same edge.
//  - Reset (rst=1 at posedge): m_valid=0, s_valid=0, m_data=s_data=RESET_DATA,
//    in_ready=1, out_valid=0, stall_cnt=0. rst overrides flush and all handshakes.
//  - States: EMPTY(m=0,s=0), ONE(m=1,s=0), TWO(m=1,s=1). s_valid=1 with m_valid=0
//    is illegal and must never occur.
//  - EMPTY: in_valid -> ONE, m_data<=in_data. Otherwise stay.
//  - ONE:  in_valid&out_ready -> ONE, m_data<=in_data (back-to-back, no bubble);
//          in_valid&~out_ready -> TWO, s_data<=in_data;
//          ~in_valid&out_ready -> EMPTY; else hold.
//  - TWO:  in_ready=0, in_valid ignored. out_ready -> ONE, m_data<=s_data; else hold.
//  - Latency: in->out 1 cycle when EMPTY/ONE; throughput 1 transfer/cycle sustained.
//  - Data in a held register is stable while its valid=1 and not consumed.
//  - flush=1 (rst=0): next state EMPTY regardless of in_valid/out_ready; entry
//    offered on in_valid that cycle is dropped (upstream must treat it as squashed);
//    data registers may keep old contents (don't care while valid=0).
//  - out_ready while out_valid=0 has no effect; in_valid while in_ready=0 has no effect.
//  - No X on out_valid/in_ready after reset under any input sequence.
// CONFIGURATION
//  PIPE_STALL_CNT_EN defined: stall_cnt port exists; increments by 1 each cycle with
//   out_valid=1 & out_ready=0; saturates at all-ones (no wrap); cleared only by rst,
//   not by flush; counts the flush cycle too if condition holds before the edge.
//  PIPE_STALL_CNT_EN undefined: stall_cnt port and counter absent; all other
//   behaviour identical, cycle for cycle.
// TESTING
//  1 rst 2 cycles -> out_valid=0, in_ready=1, out_data=RESET_DATA, stall_cnt=0.
//  2 out_ready=1, in_valid=1 data 1..8 on 8 cycles -> out_data 1..8 one cycle later,
//    out_valid=1 each cycle, in_ready stays 1, no bubble.
//  3 out_ready=0, push A,B -> state TWO, in_ready=0, C held on in_valid is ignored;
//    then out_ready=1 -> A then B delivered in order, in_ready=1 after A leaves.
//  4 state TWO (A,B held), flush=1 with in_valid=1 data C -> next cycle out_valid=0,
//    in_ready=1; C, A, B never appear on out_data.
//  5 with PIPE_STALL_CNT_EN, CNT_W=4: hold out_valid=1,out_ready=0 for 20 cycles ->
//    stall_cnt=15 (saturated); flush -> stall_cnt still 15; rst -> 0.
//  6 random in_valid/out_ready/flush 10k cycles vs reference queue model: order kept,
//    no loss/dup except flush-dropped entries, s_valid&~m_valid never seen.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage register with a 2-entry skid buffer and flush
// Ports: clk, rst (sync, active-high), flush, in_valid/in_ready/in_data (upstream),
//   out_valid/out_ready/out_data (downstream), stall_cnt (only when PIPE_STALL_CNT_EN is defined).
// Macro PIPE_STALL_CNT_EN adds a saturating counter of cycles with out_valid & ~out_ready.
module pipe_skid_reg #(
  parameter int DATA_W = 38,
  parameter logic [DATA_W-1:0] RESET_DATA = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);
  // state bit 0 is m_valid, bit 1 is s_valid, so both handshake outputs come straight off flops
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b11} state_t;
  state_t st_q, st_d;
  logic [DATA_W-1:0] m_q, m_d, s_q, s_d;
  assign out_valid = st_q[0];
  assign in_ready = ~st_q[1];
  assign out_data = m_q;
  always_comb begin
    st_d = st_q;
    m_d = m_q;
    s_d = s_q;
    if (flush) st_d = EMPTY;
    else begin
      case (st_q)
        EMPTY: begin
          st_d = in_valid ? ONE : EMPTY;
          m_d = in_valid ? in_data : m_q;
        end
        ONE: begin
          st_d = (in_valid && !out_ready) ? TWO : (!in_valid && out_ready) ? EMPTY : ONE;
          m_d = (in_valid && out_ready) ? in_data : m_q;
          s_d = (in_valid && !out_ready) ? in_data : s_q;
        end
        TWO: begin
          st_d = out_ready ? ONE : TWO;
          m_d = out_ready ? s_q : m_q;
        end
        default: st_d = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= EMPTY;
      m_q <= RESET_DATA;
      s_q <= RESET_DATA;
    end else begin
      st_q <= st_d;
      m_q <= m_d;
      s_q <= s_d;
    end
  end
`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign stall_cnt = cnt_q;
  assign cnt_d = (out_valid && !out_ready && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: scoreboard bench for pipe_skid_reg against a 2-deep queue model
module tb_pipe_skid_reg;
  localparam int W = 38;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, in_ready, out_valid;
  logic [W-1:0] in_data, out_data;
`ifdef PIPE_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
  int exp_cnt = 0;
`endif
  always #5 clk = ~clk;
  pipe_skid_reg #(.DATA_W(W), .RESET_DATA('0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  logic [W-1:0] q[$];
  int checks = 0, failures = 0, delivered = 0;
  bit mon_en = 1'b0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask
  // one stimulus cycle; the model accepts an entry only when it holds fewer than two
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    bit rdy;
    @(negedge clk);
    rdy = q.size() < 2;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    flush = fl;
    #3;
    if (fl) q.delete();
    else if (iv && rdy) q.push_back(d);
  endtask
  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
`ifdef PIPE_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
    exp_cnt = 0;
`endif
    rst = 1'b0;
    q.delete();
    mon_en = 1'b1;
  endtask
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      if (out_valid && q.size() > 0) chk("out_data", out_data, q[0]);
`ifdef PIPE_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, exp_cnt);
      if (out_valid && !out_ready && exp_cnt < 15) exp_cnt++;
`endif
      if (!flush && out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        delivered++;
      end
    end
  end
  initial begin
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1'b1, W'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, W'(38'h0A), 1'b0, 1'b0);
    cycle(1'b1, W'(38'h0B), 1'b0, 1'b0);
    cycle(1'b1, W'(38'h0C), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, W'(38'h1A), 1'b0, 1'b0);
    cycle(1'b1, W'(38'h1B), 1'b0, 1'b0);
    cycle(1'b1, W'(38'h1C), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, W'(38'h2A), 1'b0, 1'b0);
    repeat (20) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
`ifdef PIPE_STALL_CNT_EN
    chk("stall_sat_after_flush", stall_cnt, 15);
`endif
    do_reset();
    for (int i = 0; i < 10000; i++)
      cycle($urandom_range(0, 99) < 60, W'({$urandom(), $urandom()}),
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    chk("delivered_enough", delivered > 2000, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
